// File: rtl/mips_hazard_ctrl_if.sv
// Bundle between the ID stage and the hazard controller.
// The ID stage drives the instruction fields in; the controller returns pipeline enables and forwarding selects.
interface mips_hazard_ctrl_if #(
    parameter int RAW = 5,
    parameter int FW  = 2
);
    logic           id_valid;
    logic [RAW-1:0] id_rs;
    logic [RAW-1:0] id_rt;
    logic           id_use_rs;
    logic           id_use_rt;
    logic           id_regwrite;
    logic [RAW-1:0] id_dst;
    logic           id_memread;
    logic           id_branch;
    logic           id_taken;
    logic           id_mdu_start;
    logic           id_mdu_use;
    logic           pc_write;
    logic           ifid_write;
    logic           ifid_flush;
    logic           idex_bubble;
    logic [FW-1:0]  fwd_a;
    logic [FW-1:0]  fwd_b;
    logic           br_fwd_a;
    logic           br_fwd_b;
    logic [15:0]    stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_regwrite, id_dst,
               id_memread, id_branch, id_taken, id_mdu_start, id_mdu_use,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
               br_fwd_a, br_fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_regwrite, id_dst,
               id_memread, id_branch, id_taken, id_mdu_start, id_mdu_use,
        output pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
               br_fwd_a, br_fwd_b, stall_cnt
    );
endinterface

// File: rtl/mips_hazard_ctrl.sv
// Hazard/forwarding controller for the pipelined MIPS core: shadows in-flight writers from EX to WB.
// The optional HI/LO busy interlock is enabled by defining MIPS_HZ_MDU_EN.
module mips_hazard_ctrl #(
    parameter int DEPTH   = 3,
    parameter int RAW     = 5,
    parameter int FW      = 2,
    parameter int MDU_LAT = 32
) (
    input  logic              GlobalClock,
    input  logic              GlobalReset,
    mips_hazard_ctrl_if.slave hz
);
    logic [DEPTH-1:0] slotValid;
    logic [DEPTH-1:0] slotRegwrite;
    logic [DEPTH-1:0] slotMemread;
    logic [RAW-1:0]   slotDst [DEPTH];
    logic [RAW-1:0]   exRs;
    logic [RAW-1:0]   exRt;
    logic             exUseRs;
    logic             exUseRt;
    logic [15:0]      stallCnt;
    logic             exHitsId;
    logic             memHitsRs;
    logic             memHitsRt;
    logic             mduStall;
    logic             stall;
    logic             issue;
    logic [FW-1:0]    fwdA;
    logic [FW-1:0]    fwdB;

    function automatic logic producerHit(input logic v, input logic rw, input logic [RAW-1:0] dst,
                                         input logic [RAW-1:0] src, input logic useSrc);
        return v & rw & (dst == src) & (src != '0) & useSrc;
    endfunction

    always_comb begin
        exHitsId  = producerHit(slotValid[0], slotRegwrite[0], slotDst[0], hz.id_rs, hz.id_use_rs)
                  | producerHit(slotValid[0], slotRegwrite[0], slotDst[0], hz.id_rt, hz.id_use_rt);
        memHitsRs = producerHit(slotValid[1], slotRegwrite[1], slotDst[1], hz.id_rs, hz.id_use_rs);
        memHitsRt = producerHit(slotValid[1], slotRegwrite[1], slotDst[1], hz.id_rt, hz.id_use_rt);
        stall     = (slotMemread[0] & exHitsId)
                  | (hz.id_branch & exHitsId)
                  | (hz.id_branch & slotMemread[1] & (memHitsRs | memHitsRt))
                  | mduStall;
        issue     = ~stall & hz.id_valid;
    end

`ifdef MIPS_HZ_MDU_EN
    logic [5:0] mduBusy;

    assign mduStall = (hz.id_mdu_use | hz.id_mdu_start) & (mduBusy != 6'd0);

    always_ff @(posedge GlobalClock) begin
        if (GlobalReset) begin
            mduBusy <= 6'd0;
        end else if (issue & hz.id_mdu_start) begin
            mduBusy <= 6'(MDU_LAT - 1);
        end else if (mduBusy != 6'd0) begin
            mduBusy <= mduBusy - 6'd1;
        end
    end
`else
    // Without the MDU, HI/LO requests can never stall.
    assign mduStall = 1'b0 & (hz.id_mdu_use | hz.id_mdu_start);
`endif

    // Bubbles enter slot0 with their use bits cleared so they never select a forward.
    always_ff @(posedge GlobalClock) begin
        if (GlobalReset) begin
            slotValid    <= '0;
            slotRegwrite <= '0;
            slotMemread  <= '0;
            for (int k = 0; k < DEPTH; k++) slotDst[k] <= '0;
            exRs         <= '0;
            exRt         <= '0;
            exUseRs      <= 1'b0;
            exUseRt      <= 1'b0;
            stallCnt     <= 16'd0;
        end else begin
            slotValid    <= {slotValid[DEPTH-2:0], issue};
            slotRegwrite <= {slotRegwrite[DEPTH-2:0], issue & hz.id_regwrite};
            slotMemread  <= {slotMemread[DEPTH-2:0], issue & hz.id_memread};
            for (int k = DEPTH - 1; k > 0; k--) slotDst[k] <= slotDst[k-1];
            slotDst[0]   <= hz.id_dst;
            exRs         <= hz.id_rs;
            exRt         <= hz.id_rt;
            exUseRs      <= issue & hz.id_use_rs;
            exUseRt      <= issue & hz.id_use_rt;
            if (stall && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
        end
    end

    always_comb begin
        fwdA = '0;
        fwdB = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (producerHit(slotValid[k], slotRegwrite[k], slotDst[k], exRs, exUseRs)) fwdA = FW'(k);
            if (producerHit(slotValid[k], slotRegwrite[k], slotDst[k], exRt, exUseRt)) fwdB = FW'(k);
        end
    end

    // Stall overrides a taken-branch flush; reset overrides everything.
    always_comb begin
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.idex_bubble = ~hz.id_valid;
        hz.ifid_flush  = hz.id_valid & hz.id_branch & hz.id_taken;
        hz.fwd_a       = fwdA;
        hz.fwd_b       = fwdB;
        hz.br_fwd_a    = hz.id_branch & memHitsRs & ~slotMemread[1];
        hz.br_fwd_b    = hz.id_branch & memHitsRt & ~slotMemread[1];
        if (stall) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
            hz.ifid_flush  = 1'b0;
        end
        if (GlobalReset) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
            hz.ifid_flush  = 1'b1;
            hz.fwd_a       = '0;
            hz.fwd_b       = '0;
            hz.br_fwd_a    = 1'b0;
            hz.br_fwd_b    = 1'b0;
        end
    end

    assign hz.stall_cnt = stallCnt;
endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Scoreboard bench for mips_hazard_ctrl: directed hazard sequences plus random instruction streams,
// checked against an age-ordered in-flight list model (MDU sequence only when MIPS_HZ_MDU_EN is defined).
module tb_mips_hazard_ctrl;
    localparam int DEPTH   = 3;
    localparam int RAW     = 5;
    localparam int FW      = 2;
    localparam int MDU_LAT = 4;

    typedef struct packed {
        logic           valid;
        logic [RAW-1:0] rs;
        logic [RAW-1:0] rt;
        logic           useRs;
        logic           useRt;
        logic           regwrite;
        logic [RAW-1:0] dst;
        logic           memread;
        logic           branch;
        logic           taken;
        logic           mduStart;
        logic           mduUse;
    } idIn_t;

    typedef struct packed {
        logic           valid;
        logic           regwrite;
        logic           memread;
        logic [RAW-1:0] dst;
        logic [RAW-1:0] rs;
        logic [RAW-1:0] rt;
        logic           useRs;
        logic           useRt;
    } rec_t;

    typedef struct packed {
        logic          pcWrite;
        logic          ifidWrite;
        logic          ifidFlush;
        logic          idexBubble;
        logic [FW-1:0] fwdA;
        logic [FW-1:0] fwdB;
        logic          brFwdA;
        logic          brFwdB;
        logic [15:0]   stallCnt;
    } exp_t;

    logic GlobalClock = 1'b0;
    logic GlobalReset = 1'b1;

    mips_hazard_ctrl_if #(.RAW(RAW), .FW(FW)) hz ();

    mips_hazard_ctrl #(.DEPTH(DEPTH), .RAW(RAW), .FW(FW), .MDU_LAT(MDU_LAT)) dut (
        .GlobalClock (GlobalClock),
        .GlobalReset (GlobalReset),
        .hz          (hz)
    );

    always #5 GlobalClock = ~GlobalClock;

    exp_t        expQ [$];
    rec_t        pipe [$];
    int unsigned modelStallCnt = 0;
    int unsigned mduLeft = 0;
    bit          lastStall = 1'b0;
    int          testsRun = 0;
    int          testsFailed = 0;

    function automatic bit hits(rec_t p, logic [RAW-1:0] src, logic useSrc);
        return p.valid && p.regwrite && (p.dst == src) && (src != 0) && useSrc;
    endfunction

    function automatic bit readsFrom(rec_t p, idIn_t s);
        return hits(p, s.rs, s.useRs) || hits(p, s.rt, s.useRt);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, required %h at %0t", name, actual, required, $time);
        end
    endtask

    // Drive one cycle of ID inputs, predict the outputs, then advance the model past the next edge.
    task automatic applyStimulus(input idIn_t s, input bit rst);
        exp_t e;
        bit   stall;
        rec_t nr;
        @(posedge GlobalClock);
        #1;
        GlobalReset     = rst;
        hz.id_valid     = s.valid;
        hz.id_rs        = s.rs;
        hz.id_rt        = s.rt;
        hz.id_use_rs    = s.useRs;
        hz.id_use_rt    = s.useRt;
        hz.id_regwrite  = s.regwrite;
        hz.id_dst       = s.dst;
        hz.id_memread   = s.memread;
        hz.id_branch    = s.branch;
        hz.id_taken     = s.taken;
        hz.id_mdu_start = s.mduStart;
        hz.id_mdu_use   = s.mduUse;

        stall = (pipe[0].memread && readsFrom(pipe[0], s))
             || (s.branch && readsFrom(pipe[0], s))
             || (s.branch && pipe[1].memread && readsFrom(pipe[1], s));
`ifdef MIPS_HZ_MDU_EN
        stall = stall || ((s.mduUse || s.mduStart) && mduLeft != 0);
`endif
        e.pcWrite    = !stall;
        e.ifidWrite  = !stall;
        e.idexBubble = stall || !s.valid;
        e.ifidFlush  = !stall && s.valid && s.branch && s.taken;
        e.fwdA = '0;
        e.fwdB = '0;
        for (int age = DEPTH - 1; age >= 1; age--) begin
            if (pipe[0].valid && hits(pipe[age], pipe[0].rs, pipe[0].useRs)) e.fwdA = FW'(age);
            if (pipe[0].valid && hits(pipe[age], pipe[0].rt, pipe[0].useRt)) e.fwdB = FW'(age);
        end
        e.brFwdA   = s.branch && !pipe[1].memread && hits(pipe[1], s.rs, s.useRs);
        e.brFwdB   = s.branch && !pipe[1].memread && hits(pipe[1], s.rt, s.useRt);
        e.stallCnt = 16'(modelStallCnt);
        if (rst) begin
            e.pcWrite = 0; e.ifidWrite = 0; e.idexBubble = 1; e.ifidFlush = 1;
            e.fwdA = '0; e.fwdB = '0; e.brFwdA = 0; e.brFwdB = 0;
        end
        expQ.push_back(e);

        if (rst) begin
            pipe.delete();
            for (int k = 0; k < DEPTH; k++) pipe.push_back('0);
            modelStallCnt = 0;
            mduLeft = 0;
            lastStall = 1'b0;
        end else begin
            if (stall && modelStallCnt < 16'hFFFF) modelStallCnt++;
            nr = '0;
            if (!stall && s.valid) nr = '{1'b1, s.regwrite, s.memread, s.dst, s.rs, s.rt, s.useRs, s.useRt};
            pipe.push_front(nr);
            void'(pipe.pop_back());
            if (!stall && s.valid && s.mduStart) mduLeft = MDU_LAT - 1;
            else if (mduLeft > 0) mduLeft--;
            lastStall = stall;
        end
    endtask

    // Hold an instruction in ID until it is accepted, as the IF/ID register would.
    task automatic issueInsn(input idIn_t s);
        int tries = 0;
        do begin
            applyStimulus(s, 1'b0);
            tries++;
        end while (lastStall && tries < 64);
        if (lastStall) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL issue_timeout: got stalled after %0d cycles, required issue", tries);
        end
    endtask

    function automatic idIn_t mkNop();
        return '0;
    endfunction

    function automatic idIn_t mkAlu(int rd, int rs, int rt);
        idIn_t s = '0;
        s.valid = 1; s.rs = RAW'(rs); s.rt = RAW'(rt); s.useRs = 1; s.useRt = 1;
        s.regwrite = 1; s.dst = RAW'(rd);
        return s;
    endfunction

    function automatic idIn_t mkLw(int rt, int base);
        idIn_t s = '0;
        s.valid = 1; s.rs = RAW'(base); s.rt = RAW'(rt); s.useRs = 1;
        s.regwrite = 1; s.dst = RAW'(rt); s.memread = 1;
        return s;
    endfunction

    function automatic idIn_t mkBeq(int rs, int rt, bit taken);
        idIn_t s = '0;
        s.valid = 1; s.rs = RAW'(rs); s.rt = RAW'(rt); s.useRs = 1; s.useRt = 1;
        s.branch = 1; s.taken = taken;
        return s;
    endfunction

    function automatic idIn_t mkRandom();
        idIn_t s;
        s.valid    = ($urandom_range(0, 7) != 0);
        s.rs       = RAW'($urandom_range(0, 3));
        s.rt       = RAW'($urandom_range(0, 3));
        s.useRs    = 1'($urandom);
        s.useRt    = 1'($urandom);
        s.regwrite = 1'($urandom);
        s.dst      = RAW'($urandom_range(0, 3));
        s.memread  = s.regwrite && ($urandom_range(0, 2) == 0);
        s.branch   = ($urandom_range(0, 3) == 0);
        s.taken    = 1'($urandom);
        s.mduStart = ($urandom_range(0, 9) == 0);
        s.mduUse   = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    // Monitor: every output cycle with a pending prediction is popped and compared field by field.
    initial begin
        exp_t e;
        forever begin
            @(negedge GlobalClock);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("pc_write",    16'(hz.pc_write),    16'(e.pcWrite));
                checkOutput("ifid_write",  16'(hz.ifid_write),  16'(e.ifidWrite));
                checkOutput("ifid_flush",  16'(hz.ifid_flush),  16'(e.ifidFlush));
                checkOutput("idex_bubble", 16'(hz.idex_bubble), 16'(e.idexBubble));
                checkOutput("fwd_a",       16'(hz.fwd_a),       16'(e.fwdA));
                checkOutput("fwd_b",       16'(hz.fwd_b),       16'(e.fwdB));
                checkOutput("br_fwd_a",    16'(hz.br_fwd_a),    16'(e.brFwdA));
                checkOutput("br_fwd_b",    16'(hz.br_fwd_b),    16'(e.brFwdB));
                checkOutput("stall_cnt",   hz.stall_cnt,        e.stallCnt);
            end
        end
    end

    initial begin
        idIn_t s;
        for (int k = 0; k < DEPTH; k++) pipe.push_back('0);
        GlobalReset = 1'b1;
        hz.id_valid = 0; hz.id_rs = '0; hz.id_rt = '0; hz.id_use_rs = 0; hz.id_use_rt = 0;
        hz.id_regwrite = 0; hz.id_dst = '0; hz.id_memread = 0; hz.id_branch = 0; hz.id_taken = 0;
        hz.id_mdu_start = 0; hz.id_mdu_use = 0;
        repeat (2) @(posedge GlobalClock);
        applyStimulus(mkNop(), 1'b1);

        // Load-use: one stall, then the add picks the load value up from WB.
        issueInsn(mkLw(2, 1));
        issueInsn(mkAlu(3, 2, 4));
        repeat (3) issueInsn(mkNop());

        // Back-to-back ALU dependency, then the same with a nop between.
        issueInsn(mkAlu(2, 1, 1));
        issueInsn(mkAlu(3, 2, 2));
        issueInsn(mkNop());
        issueInsn(mkAlu(2, 1, 1));
        issueInsn(mkNop());
        issueInsn(mkAlu(3, 2, 2));
        repeat (3) issueInsn(mkNop());

        // Branch on an ALU result (one stall) and on a load result (two stalls).
        issueInsn(mkAlu(2, 1, 1));
        issueInsn(mkBeq(2, 5, 1'b1));
        repeat (3) issueInsn(mkNop());
        issueInsn(mkLw(2, 1));
        issueInsn(mkBeq(2, 5, 1'b1));
        repeat (3) issueInsn(mkNop());

        // Writes to $0 never create a dependency.
        issueInsn(mkAlu(0, 1, 1));
        issueInsn(mkAlu(3, 0, 0));
        repeat (3) issueInsn(mkNop());

`ifdef MIPS_HZ_MDU_EN
        s = mkNop(); s.valid = 1; s.useRs = 1; s.useRt = 1; s.rs = 5'd1; s.rt = 5'd2; s.mduStart = 1;
        issueInsn(s);
        s = mkNop(); s.valid = 1; s.regwrite = 1; s.dst = 5'd3; s.mduUse = 1;
        issueInsn(s);
        repeat (3) issueInsn(mkNop());
`endif

        // Reset lands in the load-use stall cycle; the add must issue cleanly afterwards.
        issueInsn(mkLw(2, 1));
        applyStimulus(mkAlu(3, 2, 4), 1'b1);
        issueInsn(mkAlu(3, 2, 4));
        repeat (3) issueInsn(mkNop());

        for (int n = 0; n < 1500; n++) begin
            s = mkRandom();
            if ($urandom_range(0, 49) == 0) applyStimulus(s, 1'b1);
            issueInsn(s);
        end

        repeat (4) @(negedge GlobalClock);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending predictions, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
